dmac_mch_cfg: RTL
=================

DMAC_MCH_CFG -- requirements
Module: dmac_mch_cfg

Interface
REQ-001 SHALL have parameter CH_CNT, default 4, number of DMA channels (legal 1..8).
REQ-002 SHALL have parameter LEN_W, default 16, byte-length field width (legal 12..24).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have APB ports psel_i, penable_i, pwrite_i (input, 1), paddr_i (input, 12), pwdata_i (input, 32), pready_o, pslverr_o (output, 1) and prdata_o (output, 32).
REQ-006 SHALL have ports src_addr_o and dst_addr_o, output, CH_CNT*32, packed per-channel addresses, channel n at bits [n*32 +: 32].
REQ-007 SHALL have port byte_len_o, output, CH_CNT*LEN_W, packed per-channel lengths.
REQ-008 SHALL have port start_o (output, CH_CNT), one-cycle start pulse per channel; done_i (input, CH_CNT), per-channel engine done level; irq_o (output, 1), interrupt.

Function
REQ-009 SHALL hold pready_o at 1 (zero wait states).
REQ-010 SHALL map: 0x000 VERSION (RO, 0x0002_0000 | CH_CNT); 0x004 IRQ_EN (RW, CH_CNT bits); 0x008 IRQ_STAT (RW1C); channel n base 0x100+n*0x20: +0x00 SRC, +0x04 DST, +0x08 LEN (LEN_W bits, upper bits read 0), +0x0C CMD (WO, bit0=start), +0x10 STATUS (RO, bit0=done_i[n], bit1=busy[n]).
REQ-011 SHALL register prdata_o and pslverr_o in the setup phase (psel_i & !penable_i), so both are valid in the access phase.
REQ-012 SHALL set pslverr_o for an unmapped address, a channel index >= CH_CNT, or a write to SRC/DST/LEN/CMD of a busy channel; otherwise clear it.
REQ-013 SHALL read 0 on error or write-only addresses.
REQ-014 SHALL commit a write in the access phase (psel_i & penable_i & pwrite_i) only when the registered pslverr_o is 0.
REQ-015 SHALL register the CMD start: a committed CMD write with bit0=1 pulses start_o[n] for exactly one cycle, the cycle after the access phase, and sets busy[n] on that same edge.
REQ-016 SHALL detect the rising edge of done_i[n] with one register stage; an edge while busy[n] clears busy[n] and sets IRQ_STAT[n].
REQ-017 SHALL ignore a done_i[n] edge while busy[n]=0.
REQ-018 SHALL let the set win when a W1C write and a set of IRQ_STAT[n] occur in the same cycle.
REQ-019 SHALL drive irq_o registered, = |(IRQ_STAT & IRQ_EN).
REQ-020 SHALL ignore writes to VERSION and STATUS without an error.

Reset
REQ-021 SHALL clear on rst all of: SRC, DST, LEN, IRQ_EN, IRQ_STAT, busy, done-edge flops, prdata_o, pslverr_o, start_o and irq_o.
REQ-022 SHALL, on rst mid-transfer, clear busy and suppress any pending start pulse.

Configuration
REQ-023 SHALL compile in IRQ_EN, IRQ_STAT and irq_o logic when DMAC_CFG_IRQ_EN is defined.
REQ-024 SHALL, without DMAC_CFG_IRQ_EN, tie irq_o to 0 and make 0x004/0x008 read 0 and ignore writes (no pslverr); busy tracking is unchanged.

Structure
REQ-025 SHALL place register offsets, the channel stride, the VERSION constant and an address-decode enum in package dmac_cfg_pkg.
REQ-026 SHALL instantiate one sub-module dmac_cfg_ch per channel, holding SRC/DST/LEN, busy, done-edge detect and the start pulse.

Verification
REQ-027 SHALL cover: write SRC ch1=0x1000_0000, read back -> prdata_o=0x1000_0000, pslverr_o=0.
REQ-028 SHALL cover: CMD ch0=1 -> start_o=0x1 for one cycle after the access phase; STATUS ch0 reads 0x2.
REQ-029 SHALL cover: write LEN ch0 while busy -> pslverr_o=1, LEN unchanged; raise done_i[0] -> busy cleared, IRQ_STAT=0x1.
REQ-030 SHALL cover: IRQ_EN=0x1, done edge ch0 -> irq_o=1; write IRQ_STAT=0x1 -> irq_o=0 two cycles later.
REQ-031 SHALL cover: read 0x1A0 with CH_CNT=4 -> pslverr_o=1, prdata_o=0; read 0x000 -> 0x0002_0004.
REQ-032 SHALL cover: W1C of IRQ_STAT in the same cycle as a done edge ch2 -> bit2 remains 1.

Source files
------------

// File: rtl/dmac_mch_cfg_pkg.sv
// Shared constants, address-decode enum and decode helper for the multi-channel DMA config block.
package dmac_cfg_pkg;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CH_IDX_W = 3;
    localparam int unsigned MAX_CH   = 8;

    localparam logic [ADDR_W-1:0] OFF_VERSION  = 12'h000;
    localparam logic [ADDR_W-1:0] OFF_IRQ_EN   = 12'h004;
    localparam logic [ADDR_W-1:0] OFF_IRQ_STAT = 12'h008;
    localparam logic [ADDR_W-1:0] CH_BASE      = 12'h100;
    localparam logic [ADDR_W-1:0] CH_STRIDE    = 12'h020;

    localparam logic [4:0] CH_OFF_SRC    = 5'h00;
    localparam logic [4:0] CH_OFF_DST    = 5'h04;
    localparam logic [4:0] CH_OFF_LEN    = 5'h08;
    localparam logic [4:0] CH_OFF_CMD    = 5'h0C;
    localparam logic [4:0] CH_OFF_STATUS = 5'h10;

    localparam logic [DATA_W-1:0] VERSION_BASE = 32'h0002_0000;

    typedef enum logic [3:0] {
        DEC_NONE,
        DEC_VERSION,
        DEC_IRQ_EN,
        DEC_IRQ_STAT,
        DEC_SRC,
        DEC_DST,
        DEC_LEN,
        DEC_CMD,
        DEC_STATUS
    } dec_kind_e;

    typedef struct packed {
        dec_kind_e             kind;
        logic [CH_IDX_W-1:0]   ch;
    } dec_t;

    // Map an APB address to a register kind and channel index (channel range not checked here).
    function automatic dec_t addr_decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] rel;
        dec_t              d;
        rel    = addr - CH_BASE;
        d.kind = DEC_NONE;
        d.ch   = CH_IDX_W'(rel / CH_STRIDE);
        if (addr == OFF_VERSION) begin
            d.kind = DEC_VERSION;
        end else if (addr == OFF_IRQ_EN) begin
            d.kind = DEC_IRQ_EN;
        end else if (addr == OFF_IRQ_STAT) begin
            d.kind = DEC_IRQ_STAT;
        end else if (addr >= CH_BASE && addr < CH_BASE + ADDR_W'(MAX_CH) * CH_STRIDE) begin
            case (5'(rel % CH_STRIDE))
                CH_OFF_SRC:    d.kind = DEC_SRC;
                CH_OFF_DST:    d.kind = DEC_DST;
                CH_OFF_LEN:    d.kind = DEC_LEN;
                CH_OFF_CMD:    d.kind = DEC_CMD;
                CH_OFF_STATUS: d.kind = DEC_STATUS;
                default:       d.kind = DEC_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/dmac_mch_cfg_if.sv
// APB slave bus bundle for the DMA configuration block.
interface dmac_mch_cfg_if;
    import dmac_cfg_pkg::*;

    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [DATA_W-1:0] pwdata_i;
    logic              pready_o;
    logic              pslverr_o;
    logic [DATA_W-1:0] prdata_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  pready_o, pslverr_o, prdata_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output pready_o, pslverr_o, prdata_o
    );

endinterface

// File: rtl/dmac_mch_cfg_ch.sv
// One DMA channel: address/length registers, busy tracking, done-edge detect, start pulse.
module dmac_cfg_ch
    import dmac_cfg_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_src,
    input  logic              wr_dst,
    input  logic              wr_len,
    input  logic              start_req,
    input  logic [DATA_W-1:0] wdata,
    input  logic              done_i,
    output logic [DATA_W-1:0] src_addr_o,
    output logic [DATA_W-1:0] dst_addr_o,
    output logic [LEN_W-1:0]  byte_len_o,
    output logic              busy_o,
    output logic              start_o,
    output logic              done_evt_c
);

    logic done_q;

    // A done rising edge only counts while the channel is running.
    assign done_evt_c = done_i & ~done_q & busy_o;

    // Channel registers; start and done cannot coincide since starts need an idle channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_addr_o <= '0;
            dst_addr_o <= '0;
            byte_len_o <= '0;
            busy_o     <= 1'b0;
            start_o    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q  <= done_i;
            start_o <= start_req;
            if (wr_src) src_addr_o <= wdata;
            if (wr_dst) dst_addr_o <= wdata;
            if (wr_len) byte_len_o <= wdata[LEN_W-1:0];
            if (start_req)       busy_o <= 1'b1;
            else if (done_evt_c) busy_o <= 1'b0;
        end
    end

endmodule

// File: rtl/dmac_mch_cfg.sv
// Multi-channel DMA configuration block with a zero-wait-state APB slave.
// Optional interrupt logic (IRQ_EN, IRQ_STAT, irq_o) is built when DMAC_CFG_IRQ_EN is defined.
module dmac_mch_cfg
    import dmac_cfg_pkg::*;
#(
    parameter int unsigned CH_CNT = 4,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    dmac_mch_cfg_if.slave           apb,
    output logic [CH_CNT*32-1:0]    src_addr_o,
    output logic [CH_CNT*32-1:0]    dst_addr_o,
    output logic [CH_CNT*LEN_W-1:0] byte_len_o,
    output logic [CH_CNT-1:0]       start_o,
    input  logic [CH_CNT-1:0]       done_i,
    output logic                    irq_o
);

    dec_t              dec_c;
    logic              setup_c;
    logic              access_wr_c;
    logic              err_c;
    logic [DATA_W-1:0] rdata_c;
    logic              ch_ok_c;
    logic              ch_busy_c;
    logic              ch_done_c;
    logic [DATA_W-1:0] ch_src_c;
    logic [DATA_W-1:0] ch_dst_c;
    logic [LEN_W-1:0]  ch_len_c;
    logic [DATA_W-1:0] irq_en_rd_c;
    logic [DATA_W-1:0] irq_stat_rd_c;
    logic [CH_CNT-1:0] busy;
    logic [CH_CNT-1:0] done_evt_c;
    logic [CH_CNT-1:0] wr_src_c;
    logic [CH_CNT-1:0] wr_dst_c;
    logic [CH_CNT-1:0] wr_len_c;
    logic [CH_CNT-1:0] start_req_c;
    logic [DATA_W-1:0] prdata_q;
    logic              pslverr_q;

    assign setup_c     = apb.psel_i & ~apb.penable_i;
    assign access_wr_c = apb.psel_i & apb.penable_i & apb.pwrite_i & ~pslverr_q;
    assign dec_c       = addr_decode(apb.paddr_i);

    assign apb.pready_o  = 1'b1;
    assign apb.prdata_o  = prdata_q;
    assign apb.pslverr_o = pslverr_q;

    // Select the addressed channel, then form the error flag and read data.
    always_comb begin
        ch_ok_c   = 1'b0;
        ch_busy_c = 1'b0;
        ch_done_c = 1'b0;
        ch_src_c  = '0;
        ch_dst_c  = '0;
        ch_len_c  = '0;
        err_c     = 1'b0;
        rdata_c   = '0;
        for (int unsigned n = 0; n < CH_CNT; n++) begin
            if (dec_c.ch == CH_IDX_W'(n)) begin
                ch_ok_c   = 1'b1;
                ch_busy_c = busy[n];
                ch_done_c = done_i[n];
                ch_src_c  = src_addr_o[n*32 +: 32];
                ch_dst_c  = dst_addr_o[n*32 +: 32];
                ch_len_c  = byte_len_o[n*LEN_W +: LEN_W];
            end
        end
        case (dec_c.kind)
            DEC_VERSION:  rdata_c = VERSION_BASE | DATA_W'(CH_CNT);
            DEC_IRQ_EN:   rdata_c = irq_en_rd_c;
            DEC_IRQ_STAT: rdata_c = irq_stat_rd_c;
            DEC_SRC:      rdata_c = ch_src_c;
            DEC_DST:      rdata_c = ch_dst_c;
            DEC_LEN:      rdata_c = DATA_W'(ch_len_c);
            DEC_CMD:      rdata_c = '0;
            DEC_STATUS:   rdata_c = DATA_W'({ch_busy_c, ch_done_c});
            default:      err_c   = 1'b1;
        endcase
        if (dec_c.kind inside {DEC_SRC, DEC_DST, DEC_LEN, DEC_CMD, DEC_STATUS} && !ch_ok_c)
            err_c = 1'b1;
        if (dec_c.kind inside {DEC_SRC, DEC_DST, DEC_LEN, DEC_CMD} && ch_busy_c && apb.pwrite_i)
            err_c = 1'b1;
        if (err_c)
            rdata_c = '0;
    end

    // Per-channel write strobes for committed access-phase writes.
    always_comb begin
        wr_src_c    = '0;
        wr_dst_c    = '0;
        wr_len_c    = '0;
        start_req_c = '0;
        for (int unsigned n = 0; n < CH_CNT; n++) begin
            if (access_wr_c && dec_c.ch == CH_IDX_W'(n)) begin
                wr_src_c[n]    = (dec_c.kind == DEC_SRC);
                wr_dst_c[n]    = (dec_c.kind == DEC_DST);
                wr_len_c[n]    = (dec_c.kind == DEC_LEN);
                start_req_c[n] = (dec_c.kind == DEC_CMD) & apb.pwdata_i[0];
            end
        end
    end

    // Response is captured in the setup phase so it is stable through the access phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else if (setup_c) begin
            prdata_q  <= rdata_c;
            pslverr_q <= err_c;
        end
    end

    for (genvar n = 0; n < CH_CNT; n++) begin : g_ch
        dmac_cfg_ch #(.LEN_W(LEN_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr_src     (wr_src_c[n]),
            .wr_dst     (wr_dst_c[n]),
            .wr_len     (wr_len_c[n]),
            .start_req  (start_req_c[n]),
            .wdata      (apb.pwdata_i),
            .done_i     (done_i[n]),
            .src_addr_o (src_addr_o[n*32 +: 32]),
            .dst_addr_o (dst_addr_o[n*32 +: 32]),
            .byte_len_o (byte_len_o[n*LEN_W +: LEN_W]),
            .busy_o     (busy[n]),
            .start_o    (start_o[n]),
            .done_evt_c (done_evt_c[n])
        );
    end

`ifdef DMAC_CFG_IRQ_EN
    logic [CH_CNT-1:0] irq_en_q;
    logic [CH_CNT-1:0] irq_stat_q;
    logic [CH_CNT-1:0] w1c_c;
    logic              irq_q;

    assign w1c_c = (access_wr_c && dec_c.kind == DEC_IRQ_STAT) ? apb.pwdata_i[CH_CNT-1:0] : '0;

    // Interrupt enable/status; a same-cycle done event beats the W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (access_wr_c && dec_c.kind == DEC_IRQ_EN)
                irq_en_q <= apb.pwdata_i[CH_CNT-1:0];
            irq_stat_q <= (irq_stat_q & ~w1c_c) | done_evt_c;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign irq_en_rd_c   = DATA_W'(irq_en_q);
    assign irq_stat_rd_c = DATA_W'(irq_stat_q);
    assign irq_o         = irq_q;
`else
    logic unused_done_evt;

    assign unused_done_evt = ^done_evt_c;
    assign irq_en_rd_c     = '0;
    assign irq_stat_rd_c   = '0;
    assign irq_o           = 1'b0;
`endif

endmodule
